// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer with 2-bit direction counters and round-robin replacement.
// Optional return address stack enabled by defining BTB_RAS_EN.
module branch_target_buffer #(
    parameter int ENTRIES   = 8,
    parameter int TAG_W     = 20,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        predict_hit,
    output logic        predict_taken,
    output logic [31:0] predict_bias,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_bias,
    input  logic        upd_is_call,
    input  logic        upd_is_ret,
    input  logic        flush
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic             valid_q [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      bias_q  [ENTRIES];
    logic [IDX_W-1:0] repl_ptr_q;

    logic [TAG_W-1:0] lookup_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             hit;
    logic [1:0]       hit_cnt;
    logic [31:0]      hit_bias;
    logic             upd_hit;
    logic [IDX_W-1:0] upd_idx;
    logic             wr_en;

    // Low PC bits (and upper bits above the tag) carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    assign lookup_tag = lookup_pc[TAG_W+1:2];
    assign upd_tag    = upd_pc[TAG_W+1:2];
    assign wr_en      = !rst && !flush && upd_valid;

`ifdef BTB_RAS_EN
    localparam int RAS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic              is_ret_q  [ENTRIES];
    logic [31:0]       ras_mem   [RAS_DEPTH];
    logic [RAS_W-1:0]  ras_top_q;
    logic [RAS_W:0]    ras_count_q;
    logic              hit_ret;
    logic              ras_push;
    logic              ras_pop;

    assign ras_push = wr_en && upd_is_call;
    assign ras_pop  = wr_en && upd_is_ret && (ras_count_q != '0);
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = upd_is_call ^ upd_is_ret;
`endif

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        hit_cnt  = 2'b00;
        hit_bias = '0;
`ifdef BTB_RAS_EN
        hit_ret  = 1'b0;
`endif
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == lookup_tag) begin
                hit      = 1'b1;
                hit_cnt  = cnt_q[i];
                hit_bias = bias_q[i];
`ifdef BTB_RAS_EN
                hit_ret  = is_ret_q[i];
`endif
            end
        end
    end

    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == upd_tag) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        predict_hit   = hit;
        predict_taken = hit && hit_cnt[1];
        predict_bias  = predict_taken ? hit_bias : 32'd4;
`ifdef BTB_RAS_EN
        // A trained return with a live stack entry predicts the pushed return address.
        if (hit && hit_ret && hit_cnt[1] && ras_count_q != '0)
            predict_bias = ras_mem[ras_top_q] - lookup_pc;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b00;
            end
            repl_ptr_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++)
                valid_q[i] <= 1'b0;
            repl_ptr_q <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken && cnt_q[upd_idx] != 2'b11)
                    cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'b01;
                else if (!upd_taken && cnt_q[upd_idx] != 2'b00)
                    cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'b01;
            end else if (upd_taken) begin
                valid_q[repl_ptr_q] <= 1'b1;
                cnt_q[repl_ptr_q]   <= 2'b10;
                repl_ptr_q          <= repl_ptr_q + IDX_W'(1);
            end
        end
    end

    // NOTE: tag/bias storage is not reset; its contents are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (upd_hit) begin
                if (upd_taken)
                    bias_q[upd_idx] <= upd_bias;
`ifdef BTB_RAS_EN
                if (upd_is_ret)
                    is_ret_q[upd_idx] <= 1'b1;
`endif
            end else if (upd_taken) begin
                tag_q[repl_ptr_q]    <= upd_tag;
                bias_q[repl_ptr_q]   <= upd_bias;
`ifdef BTB_RAS_EN
                is_ret_q[repl_ptr_q] <= upd_is_ret;
`endif
            end
        end
    end

`ifdef BTB_RAS_EN
    // Circular stack: a push onto a full stack overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_top_q   <= '0;
            ras_count_q <= '0;
        end else if (ras_push && !ras_pop) begin
            ras_top_q <= ras_top_q + RAS_W'(1);
            if (ras_count_q != (RAS_W+1)'(RAS_DEPTH))
                ras_count_q <= ras_count_q + (RAS_W+1)'(1);
        end else if (ras_pop && !ras_push) begin
            ras_top_q   <= ras_top_q - RAS_W'(1);
            ras_count_q <= ras_count_q - (RAS_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push && ras_pop)
            ras_mem[ras_top_q] <= upd_pc + 32'd4;
        else if (ras_push)
            ras_mem[ras_top_q + RAS_W'(1)] <= upd_pc + 32'd4;
    end
`endif

endmodule
